// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation encoding and request record
package alu_pkg;

  localparam int ALU_N = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_N-1:0] op_a;
    logic [ALU_N-1:0] op_b;
    alu_op_e          sel;
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - synchronous request FIFO holding alu_req_t entries
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  alu_req_t                   i_req,
  input  logic                       i_pop,
  output alu_req_t                   o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_req_t           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap naturally at DEPTH; occupancy alone tells full from empty.
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Entry storage: payload only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_req;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - request FIFO, external ALU drive and registered result slot
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_op_a,
  input  logic [N-1:0]           in_op_b,
  input  logic [1:0]             in_sel,
  output logic [N-1:0]           alu_op_a,
  output logic [N-1:0]           alu_op_b,
  output logic [1:0]             alu_sel,
  input  logic [N-1:0]           alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_result,
  output logic [1:0]             out_sel,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count
);

  alu_req_t               w_req;
  alu_req_t               w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_load;
  logic [$clog2(DEPTH):0] w_count;

  logic                   r_out_valid;
  logic [N-1:0]           r_out_result;
  logic [1:0]             r_out_sel;
  logic                   r_out_zero;
  logic                   r_out_neg;

  // in_ready looks only at registered occupancy so it never combinationally
  // depends on out_ready; a full FIFO refuses even when popping this cycle.
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_load   = !w_empty && (!r_out_valid || out_ready);

  assign w_req.op_a = in_op_a;
  assign w_req.op_b = in_op_b;
  assign w_req.sel  = alu_op_e'(in_sel);

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_req   (w_req),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head entry goes straight to the ALU; zeros when idle so the ALU inputs are quiet.
  always_comb begin
    alu_op_a = '0;
    alu_op_b = '0;
    alu_sel  = 2'b00;
    if (!w_empty) begin
      alu_op_a = w_head.op_a;
      alu_op_b = w_head.op_b;
      alu_sel  = w_head.sel;
    end
  end

  // Result slot: capture on load, drain on accept, otherwise hold stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= 2'b00;
      r_out_zero   <= 1'b0;
      r_out_neg    <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_sel    <= w_head.sel;
      r_out_zero   <= (alu_result == '0);
      r_out_neg    <= alu_result[N-1];
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_sel    = r_out_sel;
  assign out_zero   = r_out_zero;
  assign out_neg    = r_out_neg;
  assign count      = w_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_op_a;
  logic [N-1:0]  in_op_b;
  logic [1:0]    in_sel;
  logic [N-1:0]  alu_op_a;
  logic [N-1:0]  alu_op_b;
  logic [1:0]    alu_sel;
  logic [N-1:0]  alu_result;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic [1:0]    out_sel;
  logic          out_zero;
  logic          out_neg;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op_a    (in_op_a),
    .in_op_b    (in_op_b),
    .in_sel     (in_sel),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .count      (count)
  );

  // Reference combinational ALU on the alu_* ports.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      2'b00: alu_result = alu_op_a + alu_op_b;
      2'b01: alu_result = alu_op_a - alu_op_b;
      2'b10: alu_result = alu_op_a & alu_op_b;
      2'b11: alu_result = alu_op_a | alu_op_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] s);
    in_valid = 1'b1;
    in_op_a  = a;
    in_op_b  = b;
    in_sel   = s;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op_a   = '0;
    in_op_b   = '0;
    in_sel    = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_alu_op_a", alu_op_a, 0);
    check("rst_alu_op_b", alu_op_b, 0);
    check("rst_alu_sel", alu_sel, 0);

    // Single ADD 5+3
    out_ready = 1'b1;
    drive(5, 3, 2'b00);
    step();
    in_valid = 1'b0;
    check("add_queued_count", count, 1);
    check("add_alu_op_a", alu_op_a, 5);
    check("add_not_yet_valid", out_valid, 0);
    step();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 8);
    check("add_zero", out_zero, 0);
    check("add_neg", out_neg, 0);
    check("add_sel", out_sel, 0);
    step();
    check("add_drained", out_valid, 0);

    // Flags: SUB 7-7 then SUB 2-5
    drive(7, 7, 2'b01);
    step();
    drive(2, 5, 2'b01);
    step();
    in_valid = 1'b0;
    check("sub0_valid", out_valid, 1);
    check("sub0_result", out_result, 32'h0000_0000);
    check("sub0_zero", out_zero, 1);
    check("sub0_neg", out_neg, 0);
    step();
    check("subneg_result", out_result, 32'hFFFF_FFFD);
    check("subneg_neg", out_neg, 1);
    check("subneg_zero", out_zero, 0);
    check("subneg_sel", out_sel, 1);
    step();
    check("sub_drained", out_valid, 0);

    // Backpressure: fill slot plus FIFO with ADD i+i
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(i, i, 2'b00);
      step();
    end
    in_valid = 1'b0;
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_hold_result", out_result, 2);
    step();
    check("stall_stable", out_result, 2);
    check("stall_count", count, 4);

    // Push attempted while full during a pop must be refused
    out_ready = 1'b1;
    drive(100, 0, 2'b00);
    check("full_pop_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    check("full_pop_count", count, 3);
    check("drain_r4", out_result, 4);
    step();
    check("drain_r6", out_result, 6);
    step();
    check("drain_r8", out_result, 8);
    step();
    check("drain_r10", out_result, 10);
    check("drain_valid", out_valid, 1);
    check("drain_count", count, 0);
    step();
    check("refused_not_seen", out_valid, 0);

    // Simultaneous push/pop at count 2
    out_ready = 1'b0;
    drive(10, 1, 2'b00);
    step();
    drive(20, 2, 2'b00);
    step();
    drive(30, 3, 2'b00);
    step();
    check("pp_count_start", count, 2);
    check("pp_head_held", out_result, 11);
    out_ready = 1'b1;
    drive(40, 4, 2'b00);
    step();
    check("pp_count_a", count, 2);
    check("pp_res_a", out_result, 22);
    drive(32'h40, 32'h04, 2'b11);
    step();
    in_valid = 1'b0;
    check("pp_count_b", count, 2);
    check("pp_res_b", out_result, 33);
    step();
    check("pp_res_c", out_result, 44);
    step();
    check("pp_res_d", out_result, 32'h44);
    check("pp_sel_d", out_sel, 3);
    check("pp_count_end", count, 0);
    step();
    check("pp_drained", out_valid, 0);

    // Reset mid-stream: 1 held + 3 queued
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(i, 0, 2'b00);
      step();
    end
    in_valid = 1'b0;
    check("mid_count", count, 3);
    check("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    out_ready = 1'b1;
    drive(32'hF0, 32'h3C, 2'b10);
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", out_result, 32'h30);
    check("post_rst_sel", out_sel, 2);
    check("post_rst_zero", out_zero, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream/downstream wrapper stage for the combinational ALU.
- Buffers operation requests in a small FIFO under a valid/ready handshake.
- Presents the FIFO head to the ALU operand and select ports, then registers the ALU result with zero/negative flags into a valid/ready output slot.
- Decouples request producers from result consumers; sustains one operation per cycle.

Parameters:
- N, 32, operand/result width in bits; must match the ALU instance.
- DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request FIFO can accept
- in_op_a  input  N  operand A
- in_op_b  input  N  operand B
- in_sel  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR
- alu_op_a  output  N  to ALU op_a
- alu_op_b  output  N  to ALU op_b
- alu_sel  output  2  to ALU sel
- alu_result  input  N  from ALU result (combinational)
- out_valid  output  1  result slot holds data
- out_ready  input  1  consumer accepts result
- out_result  output  N  registered ALU result
- out_sel  output  2  operation that produced out_result
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[N-1]
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low at clk edge):
  - wr/rd pointers = 0, count = 0.
  - out_valid = 0; out_result, out_sel, out_zero, out_neg = 0.
  - Reset mid-operation discards all queued and held results; no partial state survives.
- Push: in_valid && in_ready; entry {op_a, op_b, sel} is written at wr_ptr, wr_ptr increments mod DEPTH.
- in_ready = (count < DEPTH). It is derived from registered count only and never depends on same-cycle pop or out_ready. When full, in_ready = 0 even if a pop occurs that cycle.
- ALU drive (combinational):
  - FIFO non-empty: alu_* = head entry.
  - FIFO empty: alu_* = 0.
- Capture condition: load = (count != 0) && (!out_valid || out_ready).
  - On load: out_result <= alu_result, out_sel <= head sel, out_zero <= (alu_result == 0), out_neg <= alu_result[N-1], out_valid <= 1; head is popped, rd_ptr increments mod DEPTH.
  - No load but out_valid && out_ready: out_valid <= 0. Data fields hold their values.
  - out_valid && !out_ready: all out_* hold stable (no change while stalled).
- Simultaneous push and pop: count unchanged; pointers both advance.
- Latency: request accepted at edge t appears with out_valid = 1 after edge t+1 (one cycle in FIFO, then registered). Back-to-back throughput is 1 per cycle while out_ready = 1.
- Ordering: strict FIFO; results leave in acceptance order.
- Arithmetic: this block adds no arithmetic. ALU result is taken as N bits modulo 2^N; no carry/overflow flag.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11}
  - typedef struct packed alu_req_t {op_a, op_b, sel}, parameterised via N at package level, default 32.
- Sub-module alu_req_fifo: synchronous FIFO of alu_req_t with push, pop, head, count, full, empty.
- alu_issue_stage instantiates alu_req_fifo plus the output register and handshake logic. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Bench connects a reference ALU model on alu_*/alu_result.
- Reset then idle: rst_n low 2 cycles, in_valid = 0 -> in_ready = 1, count = 0, out_valid = 0, out_result = 0, alu_* = 0.
- Single ADD: push op_a = 5, op_b = 3, sel = 00, out_ready = 1 -> out_valid high 2 edges after push; out_result = 8, out_zero = 0, out_neg = 0, out_sel = 00.
- Flags: push SUB 7-7, then SUB 2-5 (N = 32) -> results 0x00000000 with out_zero = 1, then 0xFFFFFFFD with out_neg = 1, in order.
- Full/backpressure: out_ready = 0, push 5 requests ADD i+i for i = 1..5 -> 1st captured in output slot. Next 4 fill the FIFO (count = 4, in_ready = 0). out_result stays 2 and stable. Raise out_ready -> results 2, 4, 6, 8, 10 delivered on consecutive cycles.
- Simultaneous push/pop at count = 2 with out_ready = 1: count remains 2 and order is preserved. Push attempted at count = 4 during a pop -> not accepted.
- Reset mid-stream: 3 queued plus 1 held, assert rst_n low 1 cycle -> count = 0, out_valid = 0. Next push AND 0xF0 & 0x3C yields 0x30 as the first output.
